uart_rx_fifo: RTL

Receive-side byte buffer that sits directly downstream of the `uart` receiver. It captures each byte the receiver flags with `ready`, acknowledges it with a one-cycle `ready_clr` pulse, and stores it in a synchronous FIFO. Host logic drains the FIFO at its own pace, so back-to-back received bytes are not lost while the consumer is busy. Overflow is detected and latched rather than silently corrupting stored data.

---
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the uart receiver: captures one byte per ready
// assertion, acknowledges it with ready_clr, and queues it for the host.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              ready_clr,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               capture;
    logic               rd_acc;
    logic               wr_acc;
    logic               drop;
    logic [CNT_W-1:0]   count_next;

    // Acceptance decode; a full FIFO still takes a byte if a read frees a slot this cycle.
    always_comb begin
        capture    = (state == IDLE) && rx_ready;
        rd_acc     = rd_en && !empty;
        wr_acc     = capture && (!full || rd_acc);
        drop       = capture && !wr_acc;
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Capture FSM: one write per ready assertion, acknowledge one cycle after ACK.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= IDLE;
            ready_clr <= 1'b0;
        end else begin
            ready_clr <= (state == ACK);
            case (state)
                IDLE:     if (rx_ready) state <= ACK;
                ACK:      state <= WAIT_LOW;
                WAIT_LOW: if (!rx_ready) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk_50m) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == CNT_W'(0));
            full  <= (count_next == CNT_W'(DEPTH));
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
